// File: rtl/mem_writeback_pkg.sv
// Shared types and helpers for the memory write-back stage: FSM state, load sizes,
// the opcode-to-size decode and trap/privilege constants.
package mem_writeback_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wb_state_e;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } load_size_e;

   localparam logic [4:0] PRIV_RFE     = 5'h01;
   localparam logic [7:0] EXC_MISALIGN = 8'h05;

   // Memory opcodes carry their access size in the two low bits
   localparam logic [4:0] OP_ALU = 5'h01;
   localparam logic [4:0] OP_LW  = 5'h10;
   localparam logic [4:0] OP_LH  = 5'h11;
   localparam logic [4:0] OP_LB  = 5'h12;
   localparam logic [4:0] OP_SW  = 5'h14;
   localparam logic [4:0] OP_SH  = 5'h15;
   localparam logic [4:0] OP_SB  = 5'h16;

   function automatic load_size_e op_size(input logic [4:0] opcode);
      load_size_e size_v;
      case (opcode[1:0])
         2'b01:   size_v = SZ_HALF;
         2'b10:   size_v = SZ_BYTE;
         default: size_v = SZ_WORD;
      endcase
      return size_v;
   endfunction

   function automatic logic is_misaligned(input load_size_e size, input logic [1:0] addr_lo);
      logic mis_v;
      case (size)
         SZ_WORD: mis_v = (addr_lo != 2'b00);
         SZ_HALF: mis_v = addr_lo[0];
         default: mis_v = 1'b0;
      endcase
      return mis_v;
   endfunction

endpackage

// File: rtl/mem_writeback_align.sv
// load_align: selects the little-endian lane of a read word and zero-extends it.
module load_align
   import mem_writeback_pkg::*;
(
   input  load_size_e  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] aligned_data
);

   // Lane select and zero extension; bits below the access size are ignored
   always_comb begin
      aligned_data = 32'h0000_0000;
      case (size)
         SZ_HALF: begin
            if (addr_lo[1]) begin
               aligned_data = {16'h0000, rdata[31:16]};
            end else begin
               aligned_data = {16'h0000, rdata[15:0]};
            end
         end
         SZ_BYTE: begin
            case (addr_lo)
               2'd1:    aligned_data = {24'h00_0000, rdata[15:8]};
               2'd2:    aligned_data = {24'h00_0000, rdata[23:16]};
               2'd3:    aligned_data = {24'h00_0000, rdata[31:24]};
               default: aligned_data = {24'h00_0000, rdata[7:0]};
            endcase
         end
         default: aligned_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_writeback.sv
// Write-back stage: waits for load data, commits results to the register file and
// reports traps/RFE upstream. Define WB_MISALIGN_EXC_EN to trap misaligned accesses.
module mem_writeback
   import mem_writeback_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        halt,
   input  logic        bubble_in,
   input  logic [4:0]  opcode_in,
   input  logic [4:0]  tgt_in_1,
   input  logic [4:0]  tgt_in_2,
   input  logic [31:0] result_in_1,
   input  logic [31:0] result_in_2,
   input  logic [31:0] addr_in,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        tgts_cr,
   input  logic [31:0] mem_pc_in,
   input  logic [7:0]  exc_in,
   input  logic [4:0]  priv_type,
   input  logic [1:0]  crmov_mode_type,
   input  logic [3:0]  flags_in,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        stall_out,
   output logic        wb_we_1,
   output logic [4:0]  wb_tgt_1,
   output logic [31:0] wb_data_1,
   output logic        wb_we_2,
   output logic [4:0]  wb_tgt_2,
   output logic [31:0] wb_data_2,
   output logic        cr_we,
   output logic [3:0]  flags_out,
   output logic [31:0] wb_pc_out,
   output logic [7:0]  wb_exc_out,
   output logic        exc_in_wb,
   output logic        rfe_in_wb
);

   wb_state_e   state_r;
   load_size_e  size_s;
   logic        valid_s;
   logic        misalign_s;
   logic        pending_s;
   logic        stall_s;
   logic        commit_s;
   logic        no_exc_s;
   logic [7:0]  exc_eff_s;
   logic [31:0] load_data_s;
   logic [31:0] data_1_s;
   logic        unused_ok_s;

   assign size_s      = op_size(opcode_in);
   assign unused_ok_s = ^{addr_in[31:2], is_store, crmov_mode_type};

   load_align u_load_align (
      .size         (size_s),
      .addr_lo      (addr_in[1:0]),
      .rdata        (mem_rdata),
      .aligned_data (load_data_s)
   );

   // Validity, effective exception code and the load handshake
   always_comb begin
      valid_s    = !bubble_in && !halt;
      misalign_s = 1'b0;
`ifdef WB_MISALIGN_EXC_EN
      misalign_s = valid_s && (is_load || is_store) && is_misaligned(size_s, addr_in[1:0]);
`endif
      if (misalign_s && (exc_in == 8'h00)) begin
         exc_eff_s = EXC_MISALIGN;
      end else begin
         exc_eff_s = exc_in;
      end
      no_exc_s  = (exc_eff_s == 8'h00);
      pending_s = valid_s && is_load && no_exc_s;
      stall_s   = ((state_r == ST_IDLE) && pending_s && !mem_rvalid) ||
                  ((state_r == ST_WAIT) && !mem_rvalid);
      commit_s  = valid_s && !stall_s;
      if (is_load) begin
         data_1_s = load_data_s;
      end else begin
         data_1_s = result_in_1;
      end
   end

   assign stall_out = stall_s;

   // Load-wait FSM and registered write-back outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wb_we_1    <= 1'b0;
         wb_tgt_1   <= 5'd0;
         wb_data_1  <= 32'h0000_0000;
         wb_we_2    <= 1'b0;
         wb_tgt_2   <= 5'd0;
         wb_data_2  <= 32'h0000_0000;
         cr_we      <= 1'b0;
         flags_out  <= 4'h0;
         wb_pc_out  <= 32'h0000_0000;
         wb_exc_out <= 8'h00;
         exc_in_wb  <= 1'b0;
         rfe_in_wb  <= 1'b0;
      end else if (clk_en) begin
         if (halt) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: state_r <= (pending_s && !mem_rvalid) ? ST_WAIT : ST_IDLE;
               ST_WAIT: state_r <= mem_rvalid ? ST_IDLE : ST_WAIT;
               default: state_r <= ST_IDLE;
            endcase
         end
         if (commit_s) begin
            wb_we_1    <= (tgt_in_1 != 5'd0) && no_exc_s;
            wb_tgt_1   <= tgt_in_1;
            wb_data_1  <= data_1_s;
            wb_we_2    <= (tgt_in_2 != 5'd0) && no_exc_s;
            wb_tgt_2   <= tgt_in_2;
            wb_data_2  <= result_in_2;
            cr_we      <= tgts_cr && no_exc_s;
            flags_out  <= flags_in;
            wb_pc_out  <= mem_pc_in;
            wb_exc_out <= exc_eff_s;
            exc_in_wb  <= !no_exc_s;
            rfe_in_wb  <= (priv_type == PRIV_RFE) && no_exc_s;
         end else begin
            wb_we_1    <= 1'b0;
            wb_we_2    <= 1'b0;
            cr_we      <= 1'b0;
            exc_in_wb  <= 1'b0;
            rfe_in_wb  <= 1'b0;
         end
      end
   end

endmodule
